seg_reader: RTL

SEG_READER -- requirements
Module: seg_reader

---
 rtl/seg_reader.sv | 106 ++++++++++
 1 files changed

// File: rtl/seg_reader.sv
// seg_reader: samples a muxed active-low 7-seg bus (segments, digit_sel, clear) and recovers hex digits into value/digit_valid, pulsing frame_valid and pattern_err/err_digit
module seg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  segments,
  input  logic [3:0]  digit_sel,
  input  logic        clear,
  output logic [15:0] value,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        pattern_err,
  output logic [1:0]  err_digit
);
  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;
  state_t state, state_nx;
  logic [6:0] s_seg, p_seg;
  logic [3:0] s_sel, p_sel, cnt, cnt_nx, seen, bit_k;
  logic       same, one_hot, cap, done;
  logic [1:0] idx;
  logic [4:0] dec;
  assign same = s_seg == p_seg && s_sel == p_sel;
  assign one_hot = $onehot(~s_sel);
  assign idx = !s_sel[0] ? 2'd0 : !s_sel[1] ? 2'd1 : !s_sel[2] ? 2'd2 : 2'd3;
  assign bit_k = 4'b1 << idx;
  assign done = (seen | bit_k) == 4'hf;
  always_comb begin
    case (s_seg)
      7'b0000001: dec = 5'h10;
      7'b1001111: dec = 5'h11;
      7'b0010010: dec = 5'h12;
      7'b0000110: dec = 5'h13;
      7'b1001100: dec = 5'h14;
      7'b0100100: dec = 5'h15;
      7'b0100000: dec = 5'h16;
      7'b0001111: dec = 5'h17;
      7'b0000000: dec = 5'h18;
      7'b0000100: dec = 5'h19;
      7'b0001000: dec = 5'h1a;
      7'b1100000: dec = 5'h1b;
      7'b0110001: dec = 5'h1c;
      7'b1000010: dec = 5'h1d;
      7'b0110000: dec = 5'h1e;
      7'b0111000: dec = 5'h1f;
      default:    dec = 5'h00;
    endcase
  end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    cap = 1'b0;
    if (!same || state == IDLE) begin
      cnt_nx = '0;
      state_nx = one_hot ? SETTLE : IDLE;
    end else if (state == SETTLE) begin
      cnt_nx = cnt + 4'd1;
      cap = ({1'b0, cnt} + 5'd2) >= 5'(STABLE_CYCLES);
      state_nx = cap ? LOCKED : SETTLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      s_seg <= 7'h7f;
      s_sel <= 4'hf;
      p_seg <= 7'h7f;
      p_sel <= 4'hf;
      value <= '0;
      digit_valid <= '0;
      seen <= '0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
      err_digit <= '0;
    end else begin
      s_seg <= segments;
      s_sel <= digit_sel;
      p_seg <= s_seg;
      p_sel <= s_sel;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
      if (clear) begin
        state <= IDLE;
        cnt <= '0;
        value <= '0;
        digit_valid <= '0;
        seen <= '0;
      end else begin
        state <= state_nx;
        cnt <= cnt_nx;
        if (cap && dec[4]) begin
          value[{idx, 2'b00} +: 4] <= dec[3:0];
          digit_valid[idx] <= 1'b1;
          seen <= done ? 4'h0 : seen | bit_k;
          frame_valid <= done;
        end else if (cap) begin
          digit_valid[idx] <= 1'b0;
          seen[idx] <= 1'b0;
          pattern_err <= s_seg != 7'h7f;
          err_digit <= s_seg != 7'h7f ? idx : err_digit;
        end
      end
    end
  end
endmodule
